// File: rtl/calculator_display.sv
// calculator_display: latches a signed 16-bit result and converts it to BCD
// one double-dabble shift per clock. The result is shown on a 4-digit,
// active-low, multiplexed seven-segment display with leading-zero blanking,
// a minus sign and an "Err" pattern for values outside -999..9999.
module calculator_display #(
  parameter int SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value_in,
  input  logic        value_valid,
  output logic        busy,
  output logic [6:0]  seg,
  output logic [3:0]  anode
);

  localparam int CW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     hold_q, hold_d;
  logic [15:0]     mag_q, mag_d;
  logic [15:0]     bcd_q, bcd_d;
  logic [3:0]      sh_cnt_q, sh_cnt_d;
  logic            neg_q, neg_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic [15:0]     disp_bcd_q, disp_bcd_d;
  logic            disp_neg_q, disp_neg_d;
  logic            disp_err_q, disp_err_d;
  logic [CW-1:0]   scan_cnt_q, scan_cnt_d;
  logic [1:0]      scan_idx_q, scan_idx_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      anode_q, anode_d;

  logic            in_range_s;
  logic [15:0]     abs_s;
  logic [15:0]     adj_s;

  // Add 3 to every BCD nibble that is 5 or more (double-dabble correction).
  function automatic logic [15:0] dabble_adj(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int k = 0; k < 4; k++) begin
      if (b[k*4 +: 4] >= 4'd5) begin
        r[k*4 +: 4] = b[k*4 +: 4] + 4'd3;
      end else begin
        r[k*4 +: 4] = b[k*4 +: 4];
      end
    end
    return r;
  endfunction

  // Active-low gfedcba code for a decimal digit.
  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Glyph for one digit position: error pattern, digit, minus or blank.
  function automatic logic [6:0] glyph(input logic [1:0] idx, input logic [15:0] bcd,
                                       input logic neg, input logic err);
    logic [6:0] s;
    logic [3:0] dig;
    logic [1:0] msd;
    s = 7'h7F;
    case (idx)
      2'd0:    dig = bcd[3:0];
      2'd1:    dig = bcd[7:4];
      2'd2:    dig = bcd[11:8];
      default: dig = bcd[15:12];
    endcase
    if (bcd[15:12] != 4'd0) begin
      msd = 2'd3;
    end else if (bcd[11:8] != 4'd0) begin
      msd = 2'd2;
    end else if (bcd[7:4] != 4'd0) begin
      msd = 2'd1;
    end else begin
      msd = 2'd0;
    end
    if (err) begin
      case (idx)
        2'd3:    s = 7'h06;
        2'd2:    s = 7'h2F;
        2'd1:    s = 7'h2F;
        default: s = 7'h7F;
      endcase
    end else if (idx <= msd) begin
      s = digit_seg(dig);
    end else if (neg && ({1'b0, idx} == ({1'b0, msd} + 3'd1))) begin
      s = 7'h3F;
    end else begin
      s = 7'h7F;
    end
    return s;
  endfunction

  // Range check, magnitude and dabble correction of the current accumulator.
  always_comb begin
    in_range_s = ($signed(hold_q) >= -16'sd999) && ($signed(hold_q) <= 16'sd9999);
    abs_s      = hold_q[15] ? (16'd0 - hold_q) : hold_q;
    adj_s      = dabble_adj(bcd_q);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (value_valid) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (in_range_s) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_COMMIT;
        end
      end
      ST_SHIFT: begin
        if (sh_cnt_q == 4'd15) begin
          state_d = ST_COMMIT;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: conversion datapath, display registers and busy.
  always_comb begin
    hold_d     = hold_q;
    mag_d      = mag_q;
    bcd_d      = bcd_q;
    sh_cnt_d   = sh_cnt_q;
    neg_d      = neg_q;
    err_d      = err_q;
    disp_bcd_d = disp_bcd_q;
    disp_neg_d = disp_neg_q;
    disp_err_d = disp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (value_valid) begin
          hold_d = value_in;
        end else begin
          hold_d = hold_q;
        end
      end
      ST_CHECK: begin
        sh_cnt_d = 4'd0;
        bcd_d    = 16'd0;
        if (in_range_s) begin
          mag_d = abs_s;
          neg_d = hold_q[15];
          err_d = 1'b0;
        end else begin
          mag_d = 16'd0;
          neg_d = 1'b0;
          err_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        bcd_d    = {adj_s[14:0], mag_q[15]};
        mag_d    = {mag_q[14:0], 1'b0};
        sh_cnt_d = sh_cnt_q + 4'd1;
      end
      ST_COMMIT: begin
        disp_bcd_d = bcd_q;
        disp_neg_d = neg_q;
        disp_err_d = err_q;
      end
      default: begin
        hold_d = hold_q;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Conversion datapath and display registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q     <= 16'd0;
      mag_q      <= 16'd0;
      bcd_q      <= 16'd0;
      sh_cnt_q   <= 4'd0;
      neg_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      disp_bcd_q <= 16'd0;
      disp_neg_q <= 1'b0;
      disp_err_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      mag_q      <= mag_d;
      bcd_q      <= bcd_d;
      sh_cnt_q   <= sh_cnt_d;
      neg_q      <= neg_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      disp_bcd_q <= disp_bcd_d;
      disp_neg_q <= disp_neg_d;
      disp_err_q <= disp_err_d;
    end
  end

  // Scan timing and the segment/anode pattern for the digit currently lit.
  always_comb begin
    if (scan_cnt_q == CW'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      scan_idx_d = scan_idx_q + 2'd1;
    end else begin
      scan_cnt_d = scan_cnt_q + CW'(1);
      scan_idx_d = scan_idx_q;
    end
    seg_d   = glyph(scan_idx_q, disp_bcd_q, disp_neg_q, disp_err_q);
    anode_d = ~(4'b0001 << scan_idx_q);
  end

  // Scan counters and registered display outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt_q <= '0;
      scan_idx_q <= 2'd0;
      seg_q      <= 7'h7F;
      anode_q    <= 4'hF;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      seg_q      <= seg_d;
      anode_q    <= anode_d;
    end
  end

  assign busy  = busy_q;
  assign seg   = seg_q;
  assign anode = anode_q;

endmodule

// File: tb/tb_calculator_display.sv
// Testbench for calculator_display: directed scenarios with literal
// expectations plus randomized requests checked every cycle against a
// decimal-arithmetic model of what the display must show.
module tb_calculator_display;

  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] value_in = 16'd0;
  logic        value_valid = 1'b0;
  logic        busy;
  logic [6:0]  seg;
  logic [3:0]  anode;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // model state
  int         m_edge = 0;
  int         m_disp_val = 0;
  bit         m_disp_err = 1'b0;
  bit         m_busy = 1'b0;
  int         m_pend = 0;
  int         m_done = 0;
  logic [6:0] e_seg = 7'h7F;
  logic [3:0] e_anode = 4'hF;
  logic       e_busy = 1'b0;

  calculator_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .reset(reset), .value_in(value_in), .value_valid(value_valid),
    .busy(busy), .seg(seg), .anode(anode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] dig_code(input int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
      4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
      8: return 7'h00; 9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic bit out_of_range(input int v);
    return (v < -999) || (v > 9999);
  endfunction

  // What position pos (0 = rightmost) must show for the integer v.
  function automatic logic [6:0] exp_glyph(input int pos, input int v, input bit err);
    int mag, nd, t, p;
    if (err) begin
      case (pos)
        3: return 7'h06; 2: return 7'h2F; 1: return 7'h2F;
        default: return 7'h7F;
      endcase
    end
    mag = (v < 0) ? -v : v;
    nd = 1;
    t = mag / 10;
    while (t > 0) begin nd++; t = t / 10; end
    p = 1;
    for (int i = 0; i < pos; i++) p = p * 10;
    if (pos < nd) return dig_code((mag / p) % 10);
    if (v < 0 && pos == nd) return 7'h3F;
    return 7'h7F;
  endfunction

  // Compare every cycle, then predict the outputs after the next rising edge.
  initial begin
    int pos;
    forever begin
      @(negedge clk);
      if (!reset) begin
        e_seg = 7'h7F; e_anode = 4'hF; e_busy = 1'b0;
      end
      if (chk_en) begin
        chk("cyc_seg", 32'(seg), 32'(e_seg));
        chk("cyc_anode", 32'(anode), 32'(e_anode));
        chk("cyc_busy", 32'(busy), 32'(e_busy));
      end
      if (!reset) begin
        m_edge = 0; m_disp_val = 0; m_disp_err = 1'b0; m_busy = 1'b0;
      end else begin
        pos = (m_edge / SCAN_DIV) % 4;
        e_anode = 4'hF;
        e_anode[pos] = 1'b0;
        e_seg = exp_glyph(pos, m_disp_val, m_disp_err);
        if (!m_busy) begin
          if (value_valid) begin
            m_pend = int'($signed(value_in));
            m_busy = 1'b1;
            m_done = m_edge + (out_of_range(m_pend) ? 2 : 18);
          end
        end else if (m_edge == m_done) begin
          m_disp_val = m_pend;
          m_disp_err = out_of_range(m_pend);
          m_busy = 1'b0;
        end
        e_busy = m_busy;
        m_edge++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    value_in = v[15:0];
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
  endtask

  task automatic busy_len(input string name, input int exp);
    int cnt;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin cnt++; tick(); end
    chk(name, 32'(cnt), 32'(exp));
  endtask

  task automatic wait_digit(input int pos, input logic [6:0] exp_seg, input string name);
    logic [3:0] want;
    int n;
    want = 4'hF;
    want[pos] = 1'b0;
    n = 0;
    tick();
    while (anode !== want && n < 4 * SCAN_DIV + 4) begin tick(); n++; end
    chk({name, "_anode"}, 32'(anode), 32'(want));
    chk(name, 32'(seg), 32'(exp_seg));
  endtask

  initial begin
    logic [3:0] an_tab [4];
    int bnd [10];
    int v, cnt, r;
    an_tab = '{4'hE, 4'hD, 4'hB, 4'h7};
    bnd = '{-999, 9999, -1000, 10000, 0, -1, 1, -32768, 32767, 999};

    // reset state
    reset = 1'b0;
    tick(); tick();
    chk_en = 1'b1;
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_anode", 32'(anode), 32'hF);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b1;

    // idle scan
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("scan_anode", 32'(anode), 32'(an_tab[k / 4]));
      chk("scan_seg", 32'(seg), (k < 4) ? 32'h40 : 32'h7F);
    end

    // 1234
    send(1234);
    busy_len("busy_1234", 18);
    wait_digit(3, 7'h79, "d3_1234");
    wait_digit(2, 7'h24, "d2_1234");
    wait_digit(1, 7'h30, "d1_1234");
    wait_digit(0, 7'h19, "d0_1234");

    // -42
    send(-42);
    busy_len("busy_m42", 18);
    wait_digit(2, 7'h3F, "d2_m42");
    wait_digit(1, 7'h19, "d1_m42");
    wait_digit(0, 7'h24, "d0_m42");
    wait_digit(3, 7'h7F, "d3_m42");

    // error range
    send(10000);
    busy_len("busy_10000", 2);
    wait_digit(3, 7'h06, "d3_err");
    wait_digit(2, 7'h2F, "d2_err");
    wait_digit(1, 7'h2F, "d1_err");
    wait_digit(0, 7'h7F, "d0_err");
    send(-1000);
    busy_len("busy_m1000", 2);
    wait_digit(3, 7'h06, "d3_err2");
    wait_digit(0, 7'h7F, "d0_err2");

    // request while busy is dropped
    send(7);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      if (cnt == 4) begin
        value_in = 16'd9;
        value_valid = 1'b1;
      end else begin
        value_valid = 1'b0;
      end
      cnt++;
      tick();
    end
    value_valid = 1'b0;
    chk("busy_drop", 32'(cnt), 32'd18);
    wait_digit(0, 7'h78, "d0_seven");
    wait_digit(1, 7'h7F, "d1_seven");

    // reset mid-conversion
    send(1234);
    repeat (8) tick();
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_seg", 32'(seg), 32'h7F);
    chk("arst_anode", 32'(anode), 32'hF);
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("rel_anode", 32'(anode), 32'hE);
    chk("rel_seg", 32'(seg), 32'h40);
    wait_digit(1, 7'h7F, "d1_rel");

    // random requests, including ones while busy
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4)       v = $urandom_range(0, 9999);
      else if (r < 6)  v = -int'($urandom_range(1, 999));
      else if (r < 8)  v = bnd[$urandom_range(0, 9)];
      else             v = int'($urandom_range(0, 65535)) - 32768;
      value_in = v[15:0];
      value_valid = ($urandom_range(0, 3) == 0);
      tick();
    end
    value_valid = 1'b0;
    repeat (40) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/calculator_display.md
Name: calculator_display

Overview:
- Output-side counterpart of the calculator's debounced input stage: takes the signed result from the calculator core and drives a 4-digit multiplexed seven-segment display.
- Converts the latched binary result to BCD with a sequential double-dabble engine, one shift per clock.
- Scans the four digits using a programmable dwell time.
- Applies leading-zero blanking, a minus sign, and an error pattern for out-of-range values.

Parameters:
- SCAN_DIV, 4, clock cycles each digit stays lit (≥2). The board top overrides this to 50000.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- value_in  input  16  two's-complement result from the core
- value_valid  input  1  1-cycle request to latch value_in
- busy  output  1  conversion in progress; value_valid is ignored while high
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- anode  output  4  digit enables, active-low, one-hot; bit0 is the rightmost digit

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM=IDLE, busy=0, seg=7'h7F, anode=4'hF, scan index=0, scan counter=0.
  - Display registers hold value 0, so digit0 shows "0" and digits 3..1 are blank.
- FSM IDLE:
  - On a rising edge with value_valid=1, capture value_in into a holding register and go to CHECK; busy=1 from that edge.
  - value_valid=1 while busy=1 is dropped, not queued.
- FSM CHECK (1 cycle):
  - If value_in < -999 or > 9999: set the error flag, skip SHIFT, go to COMMIT.
  - Otherwise load the magnitude (abs) and a neg flag, clear the 16-bit BCD accumulator, go to SHIFT.
- FSM SHIFT (exactly 16 cycles):
  - Each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, magnitude} left by 1.
- FSM COMMIT (1 cycle):
  - Copy the BCD digits, neg, and error into the display registers; return to IDLE.
  - busy falls on that same edge.
- Latency:
  - Normal case: capture edge at E, display registers updated and busy=0 at E+18.
  - Error case: E+2.
- Display glyph rules:
  - Leading zeros of digits 3..1 are blank; digit0 always shows.
  - For a negative value, the minus is placed one position left of the most-significant nonzero digit (value ≤ -1 has at most 3 digits, so it always fits).
  - Error pattern: digit3='E', digit2='r', digit1='r', digit0=blank.
- Segment codes (active-low gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - minus=3F, blank=7F, E=06, r=2F.
- Scan:
  - The scan counter counts 0..SCAN_DIV-1, free-running from reset release.
  - The scan index increments mod 4 when the counter wraps.
  - seg/anode are registered from the current index and the display registers every cycle.
  - First edge after reset release: anode=1110. Each anode value persists exactly SCAN_DIV cycles. Order is 1110→1101→1011→0111→1110.
- A commit mid-dwell changes seg for the currently lit digit on the next edge; the scan phase is not disturbed.
- Reset asserted mid-conversion aborts it immediately; the partial result is discarded and outputs return to their reset values.

Test Plan:
- Reset, then run 16 cycles with no request → anode cycles 1110,1101,1011,0111, each held 4 cycles; seg=40 on 1110 and seg=7F on the other digits.
- value_in=16'd1234 with a 1-cycle valid → busy high for exactly 18 cycles; then digits 3..0 show seg 79,24,30,19.
- value_in=-16'sd42 → digit2=3F (minus), digit1=19, digit0=24, digit3=7F.
- value_in=16'd10000 and value_in=-16'sd1000 → busy high 2 cycles; digits 3..0 show 06,2F,2F,7F.
- value_valid pulsed again 5 cycles into a conversion of 7 (second value 9) → second request ignored; display shows 7 (digit0=78) and busy drops at E+18.
- Assert reset at SHIFT cycle 8 of 1234 → busy=0, seg=7F, anode=F asynchronously; after release the display shows "0".
